program_loader: RTL and testbench

//  Host-side sequencer that loads a program image into the CPU RAM over the HALT/external-RAM path.
//  It holds the CPU in HALT and accepts 16-bit words on a valid/ready stream.

---
 rtl/program_loader.sv | 202 ++++++++++++++++++++
 tb/tb_program_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Loads a program image into CPU RAM over the HALT/external-RAM path, with an optional
// readback pass that compares a 16-bit checksum before restarting the CPU.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for START; HALT may still be held after a failed load
// SETTLE   | one cycle with HALT up and the RAM quiet before any access
// FETCH    | S_READY high, waiting for the next stream word
// WRITE    | one write strobe of the captured word at ADDRESS
// VRD      | one read strobe at ptr (first entry spends a quiet cycle first)
// VWAIT    | RD_LATENCY cycles waiting for BUS_IN, sampled on the last one
// RELEASE  | CPU_RST high for RST_CYCLES cycles
// FIN      | HALT dropped, DONE pulsed
`timescale 1ns/1ps
module program_loader #(
    parameter int RD_LATENCY = 1,
    parameter int RST_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] BASE_ADDR,
    input  logic [15:0] WORD_COUNT,
    input  logic        VERIFY,
    input  logic        ABORT,
    input  logic        S_VALID,
    input  logic [15:0] S_DATA,
    output logic        S_READY,
    input  logic [15:0] BUS_IN,
    output logic        HALT,
    output logic        EXT_RAM_EN,
    output logic        EXT_RAM_RW,
    output logic [15:0] ADDRESS,
    output logic [15:0] DATA,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [15:0] CHECKSUM
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_FETCH, ST_WRITE, ST_VRD, ST_VWAIT, ST_RELEASE, ST_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ptr_q, cnt_q, base_q, count_q;
    logic [15:0] addr_q, data_q, sum_q, rb_sum_q, timer_q;
    logic        verify_q, error_q, halt_hold_q, rd_gap_q;

    logic        abort_hit, take_start, rd_sample, rb_last, rb_bad;
    logic [15:0] rb_sum_next;

    assign abort_hit   = ABORT && (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign take_start  = (state_q == ST_IDLE) && START;
    assign rd_sample   = (state_q == ST_VWAIT) && (timer_q == 16'd0);
    assign rb_sum_next = rb_sum_q + BUS_IN;
    assign rb_last     = rd_sample && (cnt_q == 16'd1);
    assign rb_bad      = rb_last && (rb_sum_next != sum_q);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and state-derived outputs; ABORT overrides every transition.
    always_comb begin
        state_d    = state_q;
        S_READY    = 1'b0;
        EXT_RAM_EN = 1'b0;
        EXT_RAM_RW = 1'b0;
        CPU_RST    = 1'b0;
        DONE       = 1'b0;
        BUSY       = (state_q != ST_IDLE);
        HALT       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                HALT = halt_hold_q;
                if (START) state_d = ST_SETTLE;
            end
            ST_SETTLE: state_d = (cnt_q == 16'd0) ? ST_RELEASE : ST_FETCH;
            ST_FETCH: begin
                S_READY = 1'b1;
                if (S_VALID) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                EXT_RAM_EN = 1'b1;
                EXT_RAM_RW = 1'b1;
                if (cnt_q == 16'd1) state_d = verify_q ? ST_VRD : ST_RELEASE;
                else                state_d = ST_FETCH;
            end
            ST_VRD: begin
                // Straight after the last write the strobe waits one cycle so
                // EXT_RAM_EN never stays high across two cycles.
                EXT_RAM_EN = !rd_gap_q;
                if (!rd_gap_q) state_d = ST_VWAIT;
            end
            ST_VWAIT: begin
                if (rd_sample) begin
                    if (rb_last) state_d = rb_bad ? ST_IDLE : ST_RELEASE;
                    else         state_d = ST_VRD;
                end
            end
            ST_RELEASE: begin
                CPU_RST = 1'b1;
                if (timer_q == 16'd0) state_d = ST_FIN;
            end
            ST_FIN: begin
                HALT    = 1'b0;
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_hit) state_d = ST_IDLE;
    end

    // Datapath: pointers, captured word, checksums, down-counting timer and sticky flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            sum_q       <= '0;
            rb_sum_q    <= '0;
            timer_q     <= '0;
            verify_q    <= 1'b0;
            error_q     <= 1'b0;
            halt_hold_q <= 1'b0;
            rd_gap_q    <= 1'b0;
        end else begin
            if (take_start) begin
                ptr_q    <= BASE_ADDR;
                cnt_q    <= WORD_COUNT;
                base_q   <= BASE_ADDR;
                count_q  <= WORD_COUNT;
                verify_q <= VERIFY;
                sum_q    <= '0;
                error_q  <= 1'b0;
            end

            if (state_d == ST_RELEASE && state_q != ST_RELEASE)
                timer_q <= 16'(RST_CYCLES - 1);
            else if (state_d == ST_VWAIT && state_q != ST_VWAIT)
                timer_q <= 16'(RD_LATENCY - 1);
            else if (timer_q != 16'd0)
                timer_q <= timer_q - 16'd1;

            if (abort_hit) begin
                error_q     <= 1'b1;
                halt_hold_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (S_VALID) begin
                            data_q <= S_DATA;
                            addr_q <= ptr_q;
                            sum_q  <= sum_q + S_DATA;
                        end
                    end
                    ST_WRITE: begin
                        if (cnt_q == 16'd1 && verify_q) begin
                            ptr_q    <= base_q;
                            cnt_q    <= count_q;
                            addr_q   <= base_q;
                            rb_sum_q <= '0;
                            rd_gap_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 16'd1;
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_VRD: rd_gap_q <= 1'b0;
                    ST_VWAIT: begin
                        if (rd_sample) begin
                            rb_sum_q <= rb_sum_next;
                            ptr_q    <= ptr_q + 16'd1;
                            cnt_q    <= cnt_q - 16'd1;
                            if (!rb_last) addr_q <= ptr_q + 16'd1;
                            if (rb_bad) begin
                                error_q     <= 1'b1;
                                halt_hold_q <= 1'b1;
                            end
                        end
                    end
                    ST_FIN: halt_hold_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign ADDRESS  = addr_q;
    assign DATA     = data_q;
    assign ERROR    = error_q;
    assign CHECKSUM = sum_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a RAM model with configurable read latency and a single
// corruptible address, a stream driver, and a scoreboard monitor that pops expected
// write/read strobes and DONE checksums as the loader presents them.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int LAT  = 2;
    localparam int RSTC = 2;

    logic        CLK = 1'b0;
    logic        RST, START, VERIFY, ABORT, S_VALID;
    logic [15:0] BASE_ADDR, WORD_COUNT, S_DATA, BUS_IN;
    logic        S_READY, HALT, EXT_RAM_EN, EXT_RAM_RW, CPU_RST, BUSY, DONE, ERROR;
    logic [15:0] ADDRESS, DATA, CHECKSUM;

    program_loader #(.RD_LATENCY(LAT), .RST_CYCLES(RSTC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .WORD_COUNT(WORD_COUNT),
        .VERIFY(VERIFY), .ABORT(ABORT), .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY),
        .BUS_IN(BUS_IN), .HALT(HALT), .EXT_RAM_EN(EXT_RAM_EN), .EXT_RAM_RW(EXT_RAM_RW),
        .ADDRESS(ADDRESS), .DATA(DATA), .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE),
        .ERROR(ERROR), .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned start_cyc = 0;
    int unsigned done_cyc  = 0;
    int          rst_run   = 0;
    logic        prev_en   = 1'b0;

    logic [31:0] exp_wr[$];    // {addr, data}
    logic [15:0] exp_rd[$];
    logic [15:0] exp_done[$];  // checksum expected at DONE
    logic [15:0] load_words[$];

    bit   [15:0] ram [0:65535];
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = '0, corrupt_mask = '0;
    logic [15:0] rd_pipe [LAT];
    logic        rd_vld  [LAT];
    logic [15:0] bus_junk = '0;

    assign BUS_IN = rd_vld[LAT-1] ? rd_pipe[LAT-1] : bus_junk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: writes land on the strobe edge, reads appear LAT cycles after the strobe.
    always @(posedge CLK) begin
        if (EXT_RAM_EN && EXT_RAM_RW) ram[ADDRESS] <= DATA;
        rd_vld[0]  <= EXT_RAM_EN && !EXT_RAM_RW;
        rd_pipe[0] <= ram[ADDRESS] ^ ((corrupt_en && ADDRESS == corrupt_addr) ? corrupt_mask : 16'h0);
        for (int i = 1; i < LAT; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_pipe[i] <= rd_pipe[i-1];
        end
        bus_junk <= 16'($urandom);
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            prev_en = 1'b0;
            rst_run = 0;
        end else begin
            if (EXT_RAM_EN) begin
                check("en_not_back_to_back", {31'd0, prev_en}, 32'd0);
                check("halt_during_strobe", {31'd0, HALT}, 32'd1);
                if (EXT_RAM_RW) begin
                    if (exp_wr.size() == 0) fail_now("unexpected_write");
                    else check("write_addr_data", {ADDRESS, DATA}, exp_wr.pop_front());
                end else begin
                    if (exp_rd.size() == 0) fail_now("unexpected_read");
                    else check("read_addr", {16'd0, ADDRESS}, {16'd0, exp_rd.pop_front()});
                end
            end else if (EXT_RAM_RW) begin
                fail_now("rw_without_en");
            end
            if (CPU_RST) begin
                rst_run++;
                check("halt_during_cpu_rst", {31'd0, HALT}, 32'd1);
                if (exp_done.size() == 0) fail_now("unexpected_cpu_rst");
            end
            if (DONE) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    check("done_checksum", {16'd0, CHECKSUM}, {16'd0, exp_done.pop_front()});
                    check("cpu_rst_length", rst_run, RSTC);
                    check("halt_low_at_done", {31'd0, HALT}, 32'd0);
                end
                rst_run  = 0;
                done_cyc = cyc;
            end
            prev_en = EXT_RAM_EN;
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {24'd0, S_READY, HALT, EXT_RAM_EN, EXT_RAM_RW, CPU_RST, BUSY, DONE, ERROR}, 32'd0);
        check({name, "_bus"}, {ADDRESS, DATA}, 32'd0);
        check({name, "_sum"}, {16'd0, CHECKSUM}, 32'd0);
    endtask

    task automatic issue_start(input logic [15:0] base, input logic [15:0] n, input logic ver,
                               input logic with_abort);
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = base; WORD_COUNT = n; VERIFY = ver; ABORT = with_abort;
        start_cyc = cyc;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        BASE_ADDR = 16'($urandom); WORD_COUNT = 16'($urandom); VERIFY = 1'($urandom);
        check("busy_after_start", {31'd0, BUSY}, 32'd1);
        check("error_cleared_by_start", {31'd0, ERROR}, 32'd0);
    endtask

    // Full load of load_words; corrupt_idx >= 0 flips read data at that word's address.
    task automatic do_load(input logic [15:0] base, input logic ver, input int corrupt_idx,
                           input int max_gap);
        int          n, idx, budget;
        logic [15:0] sum;
        logic        expect_err;
        n = load_words.size();
        sum = 16'h0;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({16'(base + i), load_words[i]});
            sum = sum + load_words[i];
            if (ver) exp_rd.push_back(16'(base + i));
        end
        expect_err = ver && (corrupt_idx >= 0) && (n > 0);
        corrupt_en = expect_err;
        if (expect_err) begin
            corrupt_addr = 16'(base + corrupt_idx);
            corrupt_mask = 16'($urandom_range(1, 65535));
        end
        if (!expect_err) exp_done.push_back(sum);
        issue_start(base, 16'(n), ver, ($urandom_range(0, 3) == 0));
        budget = 0;
        while (BUSY && budget < 4000) begin
            S_VALID = (idx < n) && ($urandom_range(0, max_gap) == 0);
            S_DATA  = S_VALID ? load_words[idx] : 16'($urandom);
            START   = ($urandom_range(0, 15) == 0);
            if (START) begin
                BASE_ADDR  = 16'($urandom);
                WORD_COUNT = 16'($urandom_range(0, 9));
            end
            #1;
            if (S_VALID && S_READY) idx++;
            @(negedge CLK);
            budget++;
        end
        START = 1'b0;
        S_VALID = 1'b0;
        if (budget >= 4000) begin
            fail_now("load_timeout");
            exp_wr.delete(); exp_rd.delete(); exp_done.delete();
        end
        check("words_consumed", idx, n);
        check("final_error", {31'd0, ERROR}, {31'd0, expect_err});
        check("final_halt", {31'd0, HALT}, {31'd0, expect_err});
        check("final_checksum", {16'd0, CHECKSUM}, {16'd0, sum});
        check("writes_left", exp_wr.size(), 0);
        check("reads_left", exp_rd.size(), 0);
        check("done_left", exp_done.size(), 0);
        if (n == 0) check("count0_done_latency", done_cyc - start_cyc, 4);
        corrupt_en = 1'b0;
    endtask

    task automatic set_words3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        load_words.delete();
        load_words.push_back(a); load_words.push_back(b); load_words.push_back(c);
    endtask

    task automatic abort_test();
        logic [15:0] w[5];
        int          idx, budget;
        logic [15:0] base;
        base = 16'($urandom);
        for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
        exp_wr.push_back({base, w[0]});
        exp_wr.push_back({16'(base + 1), w[1]});
        issue_start(base, 16'd5, 1'b1, 1'b0);
        idx = 0; budget = 0;
        while (idx < 2 && budget < 100) begin
            S_VALID = 1'b1;
            S_DATA  = w[idx];
            #1;
            if (S_READY) idx++;
            @(negedge CLK);
            budget++;
        end
        S_VALID = 1'b0;
        if (budget >= 100) fail_now("abort_feed_timeout");
        for (int k = 0; k < 5; k++) @(negedge CLK);
        check("ready_while_waiting", {31'd0, S_READY}, 32'd1);
        check("busy_while_waiting", {31'd0, BUSY}, 32'd1);
        ABORT = 1'b1; S_VALID = 1'b1; S_DATA = w[2];
        @(negedge CLK);
        ABORT = 1'b0; S_VALID = 1'b0;
        check("abort_idle", {31'd0, BUSY}, 32'd0);
        check("abort_error", {31'd0, ERROR}, 32'd1);
        check("abort_halt", {31'd0, HALT}, 32'd1);
        check("abort_quiet", {30'd0, S_READY, EXT_RAM_EN}, 32'd0);
        check("abort_checksum", {16'd0, CHECKSUM}, {16'd0, 16'(w[0] + w[1])});
        repeat (3) @(negedge CLK);
        check("halt_held_after_abort", {31'd0, HALT}, 32'd1);
        check("abort_writes_left", exp_wr.size(), 0);
        exp_rd.delete();
    endtask

    task automatic reset_in_write_test();
        int budget;
        logic [15:0] base;
        base = 16'($urandom);
        for (int i = 0; i < 4; i++) exp_wr.push_back({16'(base + i), 16'(16'hA000 + i)});
        issue_start(base, 16'd4, 1'b0, 1'b0);
        budget = 0;
        while (!(EXT_RAM_EN && EXT_RAM_RW) && budget < 100) begin
            S_VALID = 1'b1;
            S_DATA  = 16'hA000;
            @(negedge CLK);
            budget++;
        end
        S_VALID = 1'b0;
        if (budget >= 100) fail_now("write_wait_timeout");
        RST = 1'b1;
        @(negedge CLK);
        check_all_zero("reset_mid_write");
        RST = 1'b0;
        exp_wr.delete(); exp_rd.delete(); exp_done.delete();
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, ci;
        logic [15:0] base;
        logic        ver;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; VERIFY = 1'b0; S_VALID = 1'b0;
        BASE_ADDR = '0; WORD_COUNT = '0; S_DATA = '0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset_state");
        RST = 1'b0;

        set_words3(16'h1111, 16'h2222, 16'h3333);
        do_load(16'h0010, 1'b0, -1, 0);
        check("spec_checksum", {16'd0, CHECKSUM}, 32'h6666);
        set_words3(16'h1111, 16'h2222, 16'h3333);
        do_load(16'h0010, 1'b1, -1, 1);
        set_words3(16'h1111, 16'h2222, 16'h3333);
        do_load(16'h0010, 1'b1, 1, 1);
        check("bad_verify_idle", {31'd0, BUSY}, 32'd0);

        load_words.delete();
        load_words.push_back(16'hBEEF); load_words.push_back(16'h0123);
        do_load(16'hFFFF, 1'b1, -1, 2);
        load_words.delete();
        do_load(16'h4000, 1'b0, -1, 0);
        load_words.delete();
        do_load(16'h4000, 1'b1, -1, 0);

        abort_test();
        set_words3(16'hCAFE, 16'h0001, 16'hFFFF);
        do_load(16'h8000, 1'b1, -1, 2);

        reset_in_write_test();

        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(0, 7);
            base = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 4)) : 16'($urandom);
            ver = 1'($urandom);
            ci = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            load_words.delete();
            for (int k = 0; k < n; k++) load_words.push_back(16'($urandom));
            do_load(base, ver, ci, 3);
        end

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
